// File: rtl/rename_pkg.sv
// rename_pkg -- shared constants and types for the rename unit, ROB and
// physical-register free list.
//   NUM_PHYS / NUM_ARCH : physical and architectural register counts
//   PHYS_W              : physical tag width
//   DEPTH               : free-list entries (registers not in the reset map)
//   PTR_W               : free-list pointer width (index plus wrap bit)
//   phys_t, fl_ptr_t    : physical tag and free-list pointer types
package rename_pkg;

    localparam int NUM_PHYS = 64;
    localparam int NUM_ARCH = 32;
    localparam int PHYS_W   = $clog2(NUM_PHYS);
    localparam int DEPTH    = NUM_PHYS - NUM_ARCH;
    localparam int IDX_W    = $clog2(DEPTH);
    localparam int PTR_W    = IDX_W + 1;

    typedef logic [PHYS_W-1:0] phys_t;
    typedef logic [PTR_W-1:0]  fl_ptr_t;

    // Storage index of a pointer (drops the wrap bit).
    function automatic logic [IDX_W-1:0] ptr_idx(input fl_ptr_t p);
        return p[IDX_W-1:0];
    endfunction

endpackage

// File: rtl/phys_free_list.sv
// phys_free_list -- circular free list of unmapped physical registers.
// The rename stage pops tags at the speculative head, commit pushes released
// mappings at the tail and advances the committed head; a flush rewinds the
// speculative head to the committed head in one cycle.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   alloc_req    : rename wants a tag this cycle
//   alloc_valid  : a tag is available at alloc_phys
//   alloc_phys   : tag at the speculative head
//   free_en      : an instruction with a destination commits
//   free_phys    : old mapping released by that instruction
//   flush        : discard all uncommitted allocations
//   free_count   : entries between speculative head and tail (0..DEPTH)
//   err          : sticky protocol-violation flag
module phys_free_list
    import rename_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  alloc_req,
    output logic  alloc_valid,
    output phys_t alloc_phys,
    input  logic  free_en,
    input  phys_t free_phys,
    input  logic  flush,
    output phys_t free_count,
    output logic  err
);

    phys_t   mem [DEPTH];
    fl_ptr_t spec_head;
    fl_ptr_t commit_head;
    fl_ptr_t tail;
    logic    err_q;

    logic    empty;
    logic    full;
    logic    retire_ok;
    logic    push_ok;
    logic    pop_ok;
    fl_ptr_t commit_next;

    // Empty/full are judged between the speculative head and the tail, so a
    // push that would overwrite a slot still needed for flush recovery is
    // rejected as full.
    assign empty     = (tail == spec_head);
    assign full      = (ptr_idx(tail) == ptr_idx(spec_head)) &&
                       (tail[IDX_W] != spec_head[IDX_W]);
    // A retirement needs an outstanding allocation behind the speculative head.
    assign retire_ok = (commit_head != spec_head);
    assign push_ok   = free_en && (free_phys != '0) && !full && retire_ok;
    // Flush takes priority over allocation in the same cycle.
    assign pop_ok    = alloc_req && !empty && !flush;

    // Flush restores to the committed head including this cycle's retirement.
    assign commit_next = push_ok ? commit_head + fl_ptr_t'(1) : commit_head;

    // NOTE: the storage array is reset along with the pointers because the
    // reset contents (NUM_ARCH..NUM_PHYS-1) are the initial free pool, not
    // don't-care data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= phys_t'(NUM_ARCH + i);
            end
            spec_head   <= '0;
            commit_head <= '0;
            tail        <= fl_ptr_t'(DEPTH);
            err_q       <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[ptr_idx(tail)] <= free_phys;
                tail               <= tail + fl_ptr_t'(1);
            end
            commit_head <= commit_next;
            if (flush) begin
                spec_head <= commit_next;
            end else if (pop_ok) begin
                spec_head <= spec_head + fl_ptr_t'(1);
            end
            if (free_en && !push_ok) begin
                err_q <= 1'b1;
            end
        end
    end

    // All outputs come from registered state only.
    assign alloc_valid = !empty;
    assign alloc_phys  = mem[ptr_idx(spec_head)];
    assign free_count  = phys_t'(tail - spec_head);
    assign err         = err_q;

endmodule

// File: tb/tb_phys_free_list.sv
// tb_phys_free_list -- directed self-checking bench for phys_free_list.
// Inputs change 1 ns after the rising edge; outputs are sampled at the same
// point, well away from the next active edge.
module tb_phys_free_list;
    import rename_pkg::*;

    logic  clk;
    logic  rst;
    logic  alloc_req;
    logic  alloc_valid;
    phys_t alloc_phys;
    logic  free_en;
    phys_t free_phys;
    logic  flush;
    phys_t free_count;
    logic  err;

    int n_assert;
    int n_fail;

    phys_free_list dut (
        .clk        (clk),
        .rst        (rst),
        .alloc_req  (alloc_req),
        .alloc_valid(alloc_valid),
        .alloc_phys (alloc_phys),
        .free_en    (free_en),
        .free_phys  (free_phys),
        .flush      (flush),
        .free_count (free_count),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic v, input int p, input int c, input logic e);
        check({tag, ".valid"}, 32'(alloc_valid), 32'(v));
        if (v) check({tag, ".phys"}, 32'(alloc_phys), 32'(p));
        check({tag, ".count"}, 32'(free_count), 32'(c));
        check({tag, ".err"}, 32'(err), 32'(e));
    endtask

    // Asynchronous reset pulse entirely between two rising edges.
    task automatic async_reset(input string tag);
        rst = 1'b1;
        #1;
        check_outs(tag, 1'b1, 32, 32, 1'b0);
        #2;
        rst = 1'b0;
        step();
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        alloc_req = 1'b0;
        free_en   = 1'b0;
        free_phys = '0;
        flush     = 1'b0;
        #2;
        check_outs("reset", 1'b1, 32, 32, 1'b0);
        #10;
        rst = 1'b0;
        step();
        check_outs("post_reset", 1'b1, 32, 32, 1'b0);

        // Drain: tags 32..63 on consecutive cycles, then empty.
        alloc_req = 1'b1;
        for (int i = 0; i < 32; i++) begin
            check("drain.valid", 32'(alloc_valid), 32'd1);
            check("drain.phys", 32'(alloc_phys), 32'(32 + i));
            check("drain.count", 32'(free_count), 32'(32 - i));
            step();
        end
        check_outs("empty", 1'b0, 0, 0, 1'b0);
        // Request while empty stalls without error.
        step();
        check_outs("empty_stall", 1'b0, 0, 0, 1'b0);
        alloc_req = 1'b0;

        // Empty list, return tag 5: allocatable the next cycle.
        free_en   = 1'b1;
        free_phys = 6'd5;
        step();
        free_en   = 1'b0;
        check_outs("free_into_empty", 1'b1, 5, 1, 1'b0);

        // Allocate tag 5, then push tag 0: ignored, err set.
        alloc_req = 1'b1;
        step();
        alloc_req = 1'b0;
        check_outs("alloc_5", 1'b0, 0, 0, 1'b0);
        free_en   = 1'b1;
        free_phys = 6'd0;
        step();
        free_en   = 1'b0;
        check_outs("free_zero", 1'b0, 0, 0, 1'b1);
        step();
        check_outs("free_zero_sticky", 1'b0, 0, 0, 1'b1);

        // Mid-cycle async reset clears everything, err included.
        async_reset("async_rst1");

        // Full list: push of 40 ignored, err set and sticky.
        free_en   = 1'b1;
        free_phys = 6'd40;
        step();
        free_en   = 1'b0;
        check_outs("free_full", 1'b1, 32, 32, 1'b1);
        step();
        step();
        check_outs("full_err_sticky", 1'b1, 32, 32, 1'b1);
        async_reset("async_rst2");

        // Allocate 32..35, commit one (returns 7), then flush with alloc_req
        // high. Committed head = 1, tail = 33, so the restored head presents
        // 33 and the count is tail - commit_head = 32 (33..63 plus 7).
        alloc_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("pre_flush.phys", 32'(alloc_phys), 32'(32 + i));
            step();
        end
        alloc_req = 1'b0;
        check_outs("alloc4", 1'b1, 36, 28, 1'b0);
        free_en   = 1'b1;
        free_phys = 6'd7;
        step();
        free_en   = 1'b0;
        check_outs("commit1", 1'b1, 36, 29, 1'b0);
        flush     = 1'b1;
        alloc_req = 1'b1;
        step();
        flush     = 1'b0;
        alloc_req = 1'b0;
        check_outs("flush", 1'b1, 33, 32, 1'b0);
        async_reset("async_rst3");

        // Allocate 22 -> count 10, then alloc + free(9) together.
        alloc_req = 1'b1;
        repeat (22) step();
        check_outs("count10", 1'b1, 54, 10, 1'b0);
        free_en   = 1'b1;
        free_phys = 6'd9;
        step();
        free_en   = 1'b0;
        check_outs("alloc_and_free", 1'b1, 55, 10, 1'b0);
        // Remaining 55..63, then the returned 9 from the tail.
        for (int i = 0; i < 9; i++) begin
            check("tail_walk.phys", 32'(alloc_phys), 32'(55 + i));
            step();
        end
        check_outs("tail_tag", 1'b1, 9, 1, 1'b0);
        step();
        alloc_req = 1'b0;
        check_outs("final_empty", 1'b0, 0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
